// File: rtl/vga_pkg.sv
// Shared 1024x768@60 timing, sync ranges and colour constants.
// Also used by vga_display for the image size.
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int IMG_WIDTH  = H_ACTIVE;
  localparam int IMG_HEIGHT = V_ACTIVE;

  localparam logic        SYNC_POL    = 1'b0;
  localparam logic [11:0] GROUND_H    = 12'd64;
  localparam logic [11:0] SKY_RGB     = 12'h4CF;
  localparam logic [11:0] GND_RGB_A   = 12'hDB6;
  localparam logic [11:0] GND_RGB_B   = 12'hB94;
  localparam logic [9:0]  SCROLL_STEP = 10'd2;

  function automatic logic in_rng(
    input logic [10:0] c,
    input logic [10:0] lo,
    input logic [10:0] hi
  );
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// Free-running h/v raster counters with end-of-line and
// end-of-frame strobes (active region counted first).
module vga_raster_cnt #(
  parameter int H_TOTAL = vga_pkg::H_TOTAL,
  parameter int V_TOTAL = vga_pkg::V_TOTAL
) (
  input  logic        vga_clk,
  input  logic        rstn,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        eol,
  output logic        eof
);

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  assign eol = (h_cnt == H_LAST);
  assign eof = eol && (v_cnt == V_LAST);

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= eol ? '0 : h_cnt + 11'd1;
      if (eol)
        v_cnt <= eof ? '0 : v_cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing plus sky/scrolling-ground background.
// All outputs registered one stage after the counters.
module vga_timing_gen #(
  parameter int          H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int          H_FP        = vga_pkg::H_FP,
  parameter int          H_SYNC      = vga_pkg::H_SYNC,
  parameter int          H_BP        = vga_pkg::H_BP,
  parameter int          V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int          V_FP        = vga_pkg::V_FP,
  parameter int          V_SYNC      = vga_pkg::V_SYNC,
  parameter int          V_BP        = vga_pkg::V_BP,
  parameter logic        SYNC_POL    = vga_pkg::SYNC_POL,
  parameter logic [11:0] GROUND_H    = vga_pkg::GROUND_H,
  parameter logic [11:0] SKY_RGB     = vga_pkg::SKY_RGB,
  parameter logic [11:0] GND_RGB_A   = vga_pkg::GND_RGB_A,
  parameter logic [11:0] GND_RGB_B   = vga_pkg::GND_RGB_B,
  parameter logic [9:0]  SCROLL_STEP = vga_pkg::SCROLL_STEP
) (
  input  logic        vga_clk,
  input  logic        rstn,
  input  logic        scroll_en,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] rgb,
  output logic        frame_start
);

  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HA  = 11'(H_ACTIVE);
  localparam logic [10:0] HSS = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSE = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VA  = 11'(V_ACTIVE);
  localparam logic [10:0] VSS = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSE = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] VG  = 11'(V_ACTIVE - int'(GROUND_H));

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] v_ext;
  logic        eol;
  logic        eof;
  logic [9:0]  scroll_off;

  logic        de_c;
  logic        gnd_c;
  logic        hs_c;
  logic        vs_c;
  logic        fs_c;
  logic [9:0]  stripe;
  logic [11:0] rgb_c;
  logic [11:0] px_c;
  logic [11:0] py_c;

  vga_raster_cnt #(
    .H_TOTAL (H_TOT),
    .V_TOTAL (V_TOT)
  ) u_cnt (
    .vga_clk (vga_clk),
    .rstn    (rstn),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .eol     (eol),
    .eof     (eof)
  );

  assign v_ext = {1'b0, v_cnt};

  always_comb begin
    de_c   = (h_cnt < HA) && (v_ext < VA);
    gnd_c  = (v_ext >= VG);
    hs_c   = in_rng(h_cnt, HSS, HSE) ? SYNC_POL : ~SYNC_POL;
    vs_c   = in_rng(v_ext, VSS, VSE) ? SYNC_POL : ~SYNC_POL;
    fs_c   = de_c && (h_cnt == '0) && (v_cnt == '0);
    stripe = h_cnt[9:0] + scroll_off;
    px_c   = de_c ? {1'b0, h_cnt} : 12'hFFF;
    py_c   = de_c ? {2'b0, v_cnt} : 12'hFFF;
    rgb_c  = '0;
    unique case (1'b1)
      !de_c:          rgb_c = '0;
      de_c && gnd_c:  rgb_c = stripe[4] ? GND_RGB_B : GND_RGB_A;
      de_c && !gnd_c: rgb_c = SKY_RGB;
      default:        rgb_c = '0;
    endcase
  end

  // Only moves at the frame boundary so stripes never tear.
  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn)
      scroll_off <= '0;
    else if (eol && eof && scroll_en)
      scroll_off <= scroll_off + SCROLL_STEP;
  end

  always_ff @(posedge vga_clk or negedge rstn) begin
    if (!rstn) begin
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      de          <= 1'b0;
      pix_x       <= 12'hFFF;
      pix_y       <= 12'hFFF;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hs          <= hs_c;
      vs          <= vs_c;
      de          <= de_c;
      pix_x       <= px_c;
      pix_y       <= py_c;
      rgb         <= rgb_c;
      frame_start <= fs_c;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a scaled-down raster
// (84x56 total, 64x48 active) so whole frames stay short.
module tb_vga_timing_gen;

  localparam int HT = 84;
  localparam int VT = 56;
  localparam int FR = HT * VT;

  logic        vga_clk = 1'b0;
  logic        rstn = 1'b0;
  logic        scroll_en = 1'b0;
  logic        hs;
  logic        vs;
  logic        de;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [11:0] rgb;
  logic        frame_start;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_ACTIVE    (64),
    .H_FP        (4),
    .H_SYNC      (8),
    .H_BP        (8),
    .V_ACTIVE    (48),
    .V_FP        (2),
    .V_SYNC      (3),
    .V_BP        (3),
    .SYNC_POL    (1'b0),
    .GROUND_H    (12'd16),
    .SKY_RGB     (12'h4CF),
    .GND_RGB_A   (12'hDB6),
    .GND_RGB_B   (12'hB94),
    .SCROLL_STEP (10'd2)
  ) dut (
    .vga_clk     (vga_clk),
    .rstn        (rstn),
    .scroll_en   (scroll_en),
    .hs          (hs),
    .vs          (vs),
    .de          (de),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  task automatic step();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  // Advance until the bench's own raster model reaches (h,v).
  task automatic goto(input int h, input int v);
    step();
    while (!((cyc % HT) == h && ((cyc / HT) % VT) == v))
      step();
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0;
    scroll_en = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1;
    total++;
    if ({hs, vs, de, frame_start} !== 4'b1100) begin
      bad++;
      $display("FAIL rst_ctl got=%b exp=1100",
               {hs, vs, de, frame_start});
    end
    total++;
    if ({pix_x, pix_y, rgb} !== {12'hFFF, 12'hFFF, 12'h000}) begin
      bad++;
      $display("FAIL rst_pix got=%h/%h/%h exp=fff/fff/000",
               pix_x, pix_y, rgb);
    end
    rstn = 1'b1;
    step();
    cyc = 0;
    total++;
    if ({de, frame_start, pix_x, pix_y} !== {2'b11, 24'h0}) begin
      bad++;
      $display("FAIL first_px got de=%b fs=%b x=%h y=%h exp 1 1 0 0",
               de, frame_start, pix_x, pix_y);
    end
    total++;
    if (rgb !== 12'h4CF) begin
      bad++;
      $display("FAIL first_rgb got=%h exp=4cf", rgb);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < FR + 100);
    total++;
    if (n !== FR) begin
      bad++;
      $display("FAIL fs_period got=%0d exp=%0d", n, FR);
    end
  endtask

  task automatic test_line();
    int nde = 0, nhs = 0, first = -1;
    logic [11:0] px64 = '0, px63 = '0;
    goto(0, 1);
    for (int i = 0; i < HT; i++) begin
      if (de) nde++;
      if (!hs) begin
        nhs++;
        if (first < 0) first = i;
      end
      if (i == 63) px63 = pix_x;
      if (i == 64) px64 = pix_x;
      if (i < HT - 1) step();
    end
    total++;
    if (nde !== 64) begin
      bad++;
      $display("FAIL line_de got=%0d exp=64", nde);
    end
    total++;
    if (nhs !== 8 || first !== 68) begin
      bad++;
      $display("FAIL line_hs got=%0d@%0d exp=8@68", nhs, first);
    end
    total++;
    if (px63 !== 12'd63 || px64 !== 12'hFFF) begin
      bad++;
      $display("FAIL line_px got=%h,%h exp=03f,fff", px63, px64);
    end
  endtask

  task automatic test_frame();
    int nde = 0, nvs = 0, first = -1, rise = -1;
    logic [11:0] py48 = '0;
    logic prev_vs = 1'b1;
    goto(0, 0);
    for (int i = 0; i < FR; i++) begin
      if (de) nde++;
      if (!vs) begin
        nvs++;
        if (first < 0) first = i;
      end
      if (vs && !prev_vs && rise < 0) rise = i;
      prev_vs = vs;
      if (i == 48 * HT) py48 = pix_y;
      if (i < FR - 1) step();
    end
    total++;
    if (nde !== 64 * 48) begin
      bad++;
      $display("FAIL frame_de got=%0d exp=3072", nde);
    end
    total++;
    if (nvs !== 3 * HT || first !== 50 * HT) begin
      bad++;
      $display("FAIL frame_vs got=%0d@%0d exp=252@4200", nvs, first);
    end
    total++;
    if (rise !== 53 * HT) begin
      bad++;
      $display("FAIL vs_rise got=%0d exp=4452", rise);
    end
    total++;
    if (py48 !== 12'hFFF) begin
      bad++;
      $display("FAIL blank_py got=%h exp=fff", py48);
    end
  endtask

  task automatic test_background();
    goto(10, 10);
    total++;
    if ({pix_x, pix_y, rgb} !== {12'd10, 12'd10, 12'h4CF}) begin
      bad++;
      $display("FAIL bg_sky got=%h/%h/%h exp=00a/00a/4cf",
               pix_x, pix_y, rgb);
    end
    goto(0, 31);
    total++;
    if (rgb !== 12'h4CF) begin
      bad++;
      $display("FAIL bg_edge got=%h exp=4cf", rgb);
    end
    goto(0, 32);
    total++;
    if (rgb !== 12'hDB6) begin
      bad++;
      $display("FAIL gnd_0 got=%h exp=db6", rgb);
    end
    goto(16, 32);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL gnd_16 got=%h exp=b94", rgb);
    end
    goto(31, 32);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL gnd_31 got=%h exp=b94", rgb);
    end
    goto(70, 40);
    total++;
    if (rgb !== 12'h000 || pix_x !== 12'hFFF) begin
      bad++;
      $display("FAIL hblank got=%h/%h exp=000/fff", rgb, pix_x);
    end
    goto(32, 47);
    total++;
    if (rgb !== 12'hDB6) begin
      bad++;
      $display("FAIL gnd_32 got=%h exp=db6", rgb);
    end
    goto(5, 50);
    total++;
    if (rgb !== 12'h000 || pix_y !== 12'hFFF) begin
      bad++;
      $display("FAIL vblank got=%h/%h exp=000/fff", rgb, pix_y);
    end
  endtask

  task automatic test_scroll();
    scroll_en = 1'b1;
    goto(14, 32);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL scr2 got=%h exp=b94", rgb);
    end
    goto(0, 0);
    goto(0, 0);
    scroll_en = 1'b0;
    goto(9, 32);
    total++;
    if (rgb !== 12'hDB6) begin
      bad++;
      $display("FAIL scr6_9 got=%h exp=db6", rgb);
    end
    goto(10, 32);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL scr6_10 got=%h exp=b94", rgb);
    end
    scroll_en = 1'b1;
    goto(20, 40);
    scroll_en = 1'b0;
    goto(10, 47);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL midtoggle got=%h exp=b94", rgb);
    end
    goto(10, 32);
    total++;
    if (rgb !== 12'hB94) begin
      bad++;
      $display("FAIL scr_hold got=%h exp=b94", rgb);
    end
  endtask

  task automatic test_async_reset();
    goto(40, 20);
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({hs, vs, de, frame_start, pix_x, pix_y, rgb} !==
        {4'b1100, 12'hFFF, 12'hFFF, 12'h000}) begin
      bad++;
      $display("FAIL async_rst got=%b%b%b%b %h %h %h",
               hs, vs, de, frame_start, pix_x, pix_y, rgb);
    end
    repeat (2) @(posedge vga_clk);
    #1;
    rstn = 1'b1;
    step();
    cyc = 0;
    total++;
    if ({de, frame_start, pix_x, pix_y} !== {2'b11, 24'h0}) begin
      bad++;
      $display("FAIL restart got de=%b fs=%b x=%h y=%h exp 1 1 0 0",
               de, frame_start, pix_x, pix_y);
    end
    goto(10, 32);
    total++;
    if (rgb !== 12'hDB6) begin
      bad++;
      $display("FAIL scr_cleared got=%h exp=db6", rgb);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_background();
    test_scroll();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing and background generator for the 1024x768@60 Hz display path (65 MHz vga_clk). Produces hs, vs, de, pix_x, pix_y and a background rgb (sky plus scrolling striped ground), all cycle-aligned. These feed vga_display, which overlays the bird and pipe sprites. It also emits a per-frame pulse for the game-logic tick.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP / H_SYNC / H_BP, 24 / 136 / 160, horizontal porches and sync (H_TOTAL = 1344)
- V_ACTIVE, 768, visible lines
- V_FP / V_SYNC / V_BP, 3 / 6 / 29, vertical porches and sync (V_TOTAL = 806)
- SYNC_POL, 1'b0, active level of hs/vs (0 = negative sync)
- GROUND_H, 12'd64, ground band height in lines at the bottom of the screen
- SKY_RGB / GND_RGB_A / GND_RGB_B, 12'h4CF / 12'hDB6 / 12'hB94, background colours
- SCROLL_STEP, 10'd2, ground scroll in pixels per frame

Ports:
- vga_clk, input, 1, pixel clock
- rstn, input, 1, asynchronous active-low reset
- scroll_en, input, 1, ground scroll enable, sampled at frame end
- hs, output, 1, horizontal sync
- vs, output, 1, vertical sync
- de, output, 1, active-video flag
- pix_x, output, 12, active column 0..1023; 12'hFFF when de=0
- pix_y, output, 12, active line 0..767; 12'hFFF when de=0
- rgb, output, 12, background colour; 12'h000 when de=0
- frame_start, output, 1, one-cycle pulse on the first active pixel (0,0)

## Operation
- h_cnt is 11 bits, counting 0..H_TOTAL-1, then wrapping to 0. v_cnt is 10 bits and increments when h_cnt wraps, counting 0..V_TOTAL-1, then wrapping to 0.
- Counter order is active first:
  - horizontal: active 0..1023, front porch 1024..1047, sync 1048..1183, back porch 1184..1343
  - vertical: active 0..767, front porch 768..770, sync 771..776, back porch 777..805
- de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs = SYNC_POL while h_cnt is in the sync range, else ~SYNC_POL. vs follows the same rule on v_cnt.
- pix_x = {1'b0,h_cnt} and pix_y = {2'b0,v_cnt} when de=1; both are 12'hFFF when de=0. The 12'hFFF value keeps downstream sprite compares from hitting during blanking.
- Background colour, in priority order:
  - de=0: rgb = 0
  - v_cnt >= V_ACTIVE-GROUND_H (lines 704..767): rgb = GND_RGB_A if bit 4 of (h_cnt[9:0] + scroll_off), modulo 1024, is 0; else GND_RGB_B. This gives 16-px stripes with a 32-px period.
  - otherwise: rgb = SKY_RGB
- scroll_off is a 10-bit register. It updates only on the last clock of the frame (h_cnt=1343, v_cnt=805): scroll_off <= scroll_off + SCROLL_STEP, modulo 1024, if scroll_en=1; otherwise it holds.
- A scroll_en change mid-frame has no visible effect until the frame boundary, so stripes never tear within a frame.

## Timing
- Counters update every vga_clk.
- All outputs are registered one stage after the counters, so all outputs have 1 clk latency from the counter state and are mutually aligned.
- frame_start is high for exactly the one cycle in which pix_x=0, pix_y=0 and de=1. Period is 1344*806 = 1,083,264 clk.
- Rising edge of vs (negative polarity) occurs at v_cnt 777. This is before line 0, so a downstream vs-edge address reset precedes active video.
- Reset values: h_cnt=0, v_cnt=0, scroll_off=0, hs=vs=~SYNC_POL, de=0, pix_x=pix_y=12'hFFF, rgb=0, frame_start=0.
- Release from reset: the first output cycle shows pixel (0,0) with frame_start=1.
- Reset asserted mid-frame: all state returns to reset values asynchronously. There is no partial-frame recovery; the raster restarts at (0,0).

## Structure
- Shared package vga_pkg holds the 1024x768 timing constants and derived H_TOTAL/V_TOTAL, the sync ranges, and the colour constants. vga_display takes IMG_WIDTH/IMG_HEIGHT from the same package.
- One sub-module: vga_raster_cnt, holding the h/v counters, end-of-line and end-of-frame strobes. The top holds the decode, scroll register and output registers.

## Test plan
- Reset release: first output cycle has de=1, pix_x=0, pix_y=0, frame_start=1. The next frame_start follows exactly 1,083,264 clk later.
- Line timing: in a line, de is high for 1024 clk. hs is low from output h=1048 through 1183 (136 clk). pix_x is 12'hFFF at h=1024.
- Frame timing: vs is low for 6 lines (lines 771..776). de=0 for lines 768..805. pix_y=12'hFFF there.
- Background: at (100,100) rgb=12'h4CF. With scroll_off=0, (0,704) gives 12'hDB6 and (16,704) gives 12'hB94. During blanking rgb=0.
- Scroll: scroll_en=1 for 3 frames gives scroll_off=6, so (10,704) gives 12'hB94. Toggling scroll_en mid-frame leaves the current frame's stripes unchanged. 512 frames at step 2 wraps scroll_off to 0.
- Async reset asserted at pixel (500,300): outputs go to reset values without a clock edge. After release the raster restarts at (0,0) and scroll_off=0.
